// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V core front end.
package riscv_pkg;

   localparam int unsigned DEF_PC_WIDTH   = 32;
   localparam int unsigned DEF_INST_WIDTH = 32;
   localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
   localparam int unsigned DEF_BUF_DEPTH  = 2;

   // Sequential fetch advances by one 32-bit instruction word.
   localparam int unsigned PC_INCR = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRAP = 2'd2
   } fetch_state_e;

endpackage : riscv_pkg

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, inst} pairs between instruction memory and decode.
// A flush empties the FIFO and overrides any push or pop in the same cycle.
module fetch_buf #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [PC_W-1:0]   push_pc,
   input  logic [INST_W-1:0] push_inst,
   output logic [1:0]        count,
   output logic [PC_W-1:0]   head_pc,
   output logic [INST_W-1:0] head_inst
);

   logic [PC_W-1:0]   pc_mem_q   [2];
   logic [INST_W-1:0] inst_mem_q [2];

   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;

   // Next pointer and occupancy values.
   always_comb begin
      // NOTE: every signal assigned here gets its default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count gates validity, so stale data is never presented.
      if (push && !flush) begin
         pc_mem_q[wr_ptr_q]   <= push_pc;
         inst_mem_q[wr_ptr_q] <= push_inst;
      end
   end

   assign count     = count_q;
   assign head_pc   = pc_mem_q[rd_ptr_q];
   assign head_inst = inst_mem_q[rd_ptr_q];

endmodule : fetch_buf

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address,
// buffers returned words and hands {pc, inst} to decode over valid/ready.
module inst_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned                   PC_WIDTH_LENGTH   = DEF_PC_WIDTH,
   parameter int unsigned                   INST_WIDTH_LENGTH = DEF_INST_WIDTH,
   parameter logic [PC_WIDTH_LENGTH-1:0]    RESET_VECTOR      = DEF_RESET_VEC,
   parameter int unsigned                   BUF_DEPTH         = DEF_BUF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         fetch_en,
   output logic [PC_WIDTH_LENGTH-1:0]   imem_pc,
   input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
   input  logic                         redirect_valid,
   input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
   output logic                         dec_valid,
   input  logic                         dec_ready,
   output logic [INST_WIDTH_LENGTH-1:0] dec_inst,
   output logic [PC_WIDTH_LENGTH-1:0]   dec_pc,
   output logic                         misalign_trap
);

   fetch_state_e state_q, state_d;

   logic [PC_WIDTH_LENGTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic                         misalign_q, misalign_d;

   logic [1:0]                   buf_count;
   logic [PC_WIDTH_LENGTH-1:0]   head_pc;
   logic [INST_WIDTH_LENGTH-1:0] head_inst;
   logic                         buf_full;
   logic                         push;
   logic                         pop;
   logic                         redirect_misaligned;

   assign buf_full            = (buf_count == 2'(BUF_DEPTH));
   assign pop                 = dec_valid && dec_ready;
   assign push                = (state_q == ST_RUN) && fetch_en && !redirect_valid
                                && (!buf_full || pop);
   assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

   // Next-state, next-PC and trap flag; a redirect overrides normal sequencing.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      misalign_d = misalign_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         if (redirect_misaligned) begin
            state_d    = ST_TRAP;
            misalign_d = 1'b1;
         end else begin
            state_d    = fetch_en ? ST_RUN : ST_IDLE;
            misalign_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: if (fetch_en)  state_d = ST_RUN;
            ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
         endcase
         if (push) fetch_pc_d = fetch_pc_q + PC_WIDTH_LENGTH'(PC_INCR);
      end
   end

   // State, PC and trap registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_buf #(
      .PC_W   (PC_WIDTH_LENGTH),
      .INST_W (INST_WIDTH_LENGTH)
   ) u_fetch_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_pc   (fetch_pc_q),
      .push_inst (imem_inst),
      .count     (buf_count),
      .head_pc   (head_pc),
      .head_inst (head_inst)
   );

   assign imem_pc       = fetch_pc_q;
   assign dec_valid     = (buf_count != 2'd0);
   assign dec_pc        = dec_valid ? head_pc   : '0;
   assign dec_inst      = dec_valid ? head_inst : '0;
   assign misalign_trap = misalign_q;

endmodule : inst_fetch_unit
